mmu_feeder: RTL and testbench

Double-buffered operand loader and sequencer sitting directly upstream of the systolic MMU datapath. Accepts A and B matrices row-by-row into a shadow bank, and on `start` streams A columns and B rows into the two `mmu_setup` skew stages. Drives `clear` and `shift` to the structural MMU with the cycle spacing the array requires. Frees the host from cycle-counting and allows the next job to load while the current one computes.

---
 rtl/mmu_feeder.sv | 184 ++++++++++++++++++
 tb/tb_mmu_feeder.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_feeder.sv
// Double-buffered A/B operand store and job sequencer for the systolic MMU.
// Streams A columns / B rows into the setup skew stages and paces clear/shift.
module mmu_feeder #(
  parameter int unsigned VAR_SIZE = 8,
  parameter int unsigned MMU_SIZE = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic                         wr_sel,
  input  logic [7:0]                   wr_idx,
  input  logic [VAR_SIZE*MMU_SIZE-1:0] wr_data,
  input  logic                         start,
  output logic                         ready,
  output logic                         busy,
  output logic                         done,
  output logic [VAR_SIZE*MMU_SIZE-1:0] A1,
  output logic [VAR_SIZE*MMU_SIZE-1:0] B1,
  output logic                         clear,
  output logic                         shift
);

  localparam int unsigned RowW = VAR_SIZE * MMU_SIZE;
  localparam int unsigned IdxW = (MMU_SIZE > 1) ? $clog2(MMU_SIZE) : 1;
  localparam int unsigned CntW = $clog2(MMU_SIZE + 1);
  localparam logic [CntW-1:0] CntLast  = CntW'(MMU_SIZE - 1);
  localparam logic [CntW-1:0] CntDrain = CntW'(MMU_SIZE);
  localparam logic [7:0]      NumRows  = 8'(MMU_SIZE);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StFeed,
    StDrain,
    StShift
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              act_q, act_d;
  logic              pending_q, pending_d;
  logic              ready_q;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              clear_q, clear_d;
  logic              shift_q, shift_d;
  logic [RowW-1:0]   a1_q, a1_d;
  logic [RowW-1:0]   b1_q, b1_d;
  logic [IdxW-1:0]   row_sel;
  logic              wr_ok;

  // [bank][row]; element j of a row sits at bits [j*VAR_SIZE +: VAR_SIZE]
  logic [RowW-1:0]   a_bank_q [2][MMU_SIZE];
  logic [RowW-1:0]   b_bank_q [2][MMU_SIZE];

  // Shadow bank is locked while a committed job waits for IDLE.
  assign wr_ok   = wr_en && !pending_q && (wr_idx < NumRows);
  assign row_sel = cnt_q[IdxW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < MMU_SIZE; i++) begin
          a_bank_q[b][i] <= '0;
          b_bank_q[b][i] <= '0;
        end
      end
    end else if (wr_ok) begin
      if (wr_sel) begin
        b_bank_q[~act_q][wr_idx[IdxW-1:0]] <= wr_data;
      end else begin
        a_bank_q[~act_q][wr_idx[IdxW-1:0]] <= wr_data;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    act_d     = act_q;
    pending_d = pending_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    clear_d   = 1'b0;
    shift_d   = 1'b0;
    a1_d      = '0;
    b1_d      = '0;

    if (start && !pending_q) begin
      pending_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (pending_q) begin
          act_d     = ~act_q;
          pending_d = 1'b0;
          state_d   = StClear;
        end
      end
      StClear: begin
        busy_d  = 1'b1;
        clear_d = 1'b1;
        cnt_d   = '0;
        state_d = StFeed;
      end
      StFeed: begin
        busy_d = 1'b1;
        // A1 carries column k of A, B1 carries row k of B
        for (int j = 0; j < MMU_SIZE; j++) begin
          a1_d[j*VAR_SIZE +: VAR_SIZE] = a_bank_q[act_q][j][row_sel*VAR_SIZE +: VAR_SIZE];
        end
        b1_d = b_bank_q[act_q][row_sel];
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = StDrain;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDrain: begin
        // One skew cycle plus N compute cycles before results can shift out.
        busy_d = 1'b1;
        if (cnt_q == CntDrain) begin
          cnt_d   = '0;
          state_d = StShift;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StShift: begin
        busy_d  = 1'b1;
        shift_d = 1'b1;
        if (cnt_q == CntLast) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      act_q     <= 1'b0;
      pending_q <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      clear_q   <= 1'b0;
      shift_q   <= 1'b0;
      a1_q      <= '0;
      b1_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      act_q     <= act_d;
      pending_q <= pending_d;
      ready_q   <= ~pending_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      clear_q   <= clear_d;
      shift_q   <= shift_d;
      a1_q      <= a1_d;
      b1_q      <= b1_d;
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign clear = clear_q;
  assign shift = shift_q;
  assign A1    = a1_q;
  assign B1    = b1_q;

endmodule

// File: tb/tb_mmu_feeder.sv
// Directed self-checking bench for mmu_feeder: timing of clear/feed/shift,
// streamed operands and the C they produce downstream.
module tb_mmu_feeder;

  localparam int N = 10;
  localparam int V = 8;
  localparam int W = N * V;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wr_en = 1'b0;
  logic         wr_sel = 1'b0;
  logic [7:0]   wr_idx = '0;
  logic [W-1:0] wr_data = '0;
  logic         start = 1'b0;
  logic         ready, busy, done, clear, shift;
  logic [W-1:0] A1, B1;

  mmu_feeder #(.VAR_SIZE(V), .MMU_SIZE(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (wr_en),
    .wr_sel (wr_sel),
    .wr_idx (wr_idx),
    .wr_data(wr_data),
    .start  (start),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .A1     (A1),
    .B1     (B1),
    .clear  (clear),
    .shift  (shift)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Per-job observations, restarted on the first clear cycle of each job.
  int   cyc = 0;
  int   clr_cyc = -1000;
  int   clr_len = 0;
  int   shift_first = -1;
  int   shift_cnt = 0;
  int   done_cnt = 0;
  int   done_cyc = -1;
  int   last_done = -1000;
  int   busy_cnt = 0;
  int   nz_other = 0;
  int   gap = -1;
  logic prev_clear = 1'b0;
  logic [W-1:0] capA [N];
  logic [W-1:0] capB [N];

  int ea [N][N];
  int eb [N][N];
  int ec [N][N];
  int oc [N][N];

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc = cyc + 1;
      if (clear && !prev_clear) begin
        gap         = cyc - last_done - 1;
        clr_cyc     = cyc;
        clr_len     = 0;
        shift_first = -1;
        shift_cnt   = 0;
        done_cnt    = 0;
        busy_cnt    = 0;
        nz_other    = 0;
      end
      if (clear) clr_len++;
      if (busy) busy_cnt++;
      if (cyc > clr_cyc && cyc <= clr_cyc + N) begin
        capA[cyc-clr_cyc-1] = A1;
        capB[cyc-clr_cyc-1] = B1;
      end else if (A1 != '0 || B1 != '0) begin
        nz_other++;
      end
      if (shift) begin
        if (shift_first < 0) shift_first = cyc;
        shift_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc  = cyc;
        last_done = cyc;
      end
      prev_clear = clear;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] row_of(input bit sel, input int i);
    logic [W-1:0] r;
    r = '0;
    for (int j = 0; j < N; j++) begin
      r[j*V +: V] = sel ? eb[i][j][V-1:0] : ea[i][j][V-1:0];
    end
    return r;
  endfunction

  function automatic void mult();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        ec[i][j] = 0;
        for (int k = 0; k < N; k++) ec[i][j] += ea[i][k] * eb[k][j];
      end
    end
  endfunction

  // What the downstream array accumulates from the captured FEED stream.
  function automatic void stream_c();
    int a, b;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        oc[i][j] = 0;
        for (int k = 0; k < N; k++) begin
          a = $signed(capA[k][i*V +: V]);
          b = $signed(capB[k][j*V +: V]);
          oc[i][j] += a * b;
        end
      end
    end
  endfunction

  function automatic int c_errors();
    int e;
    e = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (oc[i][j] != ec[i][j]) e++;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic write_row(input bit sel, input logic [7:0] idx, input logic [W-1:0] data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_idx  = idx;
    wr_data = data;
    step();
    wr_en = 1'b0;
  endtask

  task automatic load(input int nb);
    for (int i = 0; i < N; i++) write_row(1'b0, 8'(i), row_of(1'b0, i));
    for (int i = 0; i < nb; i++) write_row(1'b1, 8'(i), row_of(1'b1, i));
  endtask

  task automatic do_start(output int t);
    start = 1'b1;
    t = cyc + 1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int i;
    i = 0;
    while (!done && i < 200) begin
      step();
      i++;
    end
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL %s_done_timeout: done=%b required 1", name, done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    tests++; if (A1 !== '0)    begin fails++; $display("FAIL reset_A1: got %h required 0", A1); end
    tests++; if (B1 !== '0)    begin fails++; $display("FAIL reset_B1: got %h required 0", B1); end
    tests++; if (clear !== 0)  begin fails++; $display("FAIL reset_clear: got %b required 0", clear); end
    tests++; if (shift !== 0)  begin fails++; $display("FAIL reset_shift: got %b required 0", shift); end
    tests++; if (done !== 0)   begin fails++; $display("FAIL reset_done: got %b required 0", done); end
    tests++; if (busy !== 0)   begin fails++; $display("FAIL reset_busy: got %b required 0", busy); end
    tests++; if (ready !== 1)  begin fails++; $display("FAIL reset_ready: got %b required 1", ready); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int t, e;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ea[i][j] = i + j;
        eb[i][j] = (i == j) ? 1 : 0;
      end
    mult();
    load(N);
    do_start(t);
    tests++; if (ready !== 0) begin fails++; $display("FAIL basic_ready_fall: got %b required 0", ready); end
    step();
    tests++; if (ready !== 1) begin fails++; $display("FAIL basic_ready_rise: got %b required 1", ready); end
    tests++; if (busy !== 0)  begin fails++; $display("FAIL basic_busy_idle: got %b required 0", busy); end
    wait_done("basic");
    tests++; if (clr_cyc - t != 2) begin fails++; $display("FAIL basic_clear_latency: got %0d required 2", clr_cyc - t); end
    tests++; if (clr_len != 1) begin fails++; $display("FAIL basic_clear_len: got %0d required 1", clr_len); end
    tests++; if (shift_first - clr_cyc != 22) begin fails++; $display("FAIL basic_shift_offset: got %0d required 22", shift_first - clr_cyc); end
    tests++; if (shift_cnt != 10) begin fails++; $display("FAIL basic_shift_len: got %0d required 10", shift_cnt); end
    tests++; if (done_cyc != shift_first + 9) begin fails++; $display("FAIL basic_done_pos: got %0d required %0d", done_cyc, shift_first + 9); end
    tests++; if (busy_cnt != 32) begin fails++; $display("FAIL basic_busy_len: got %0d required 32", busy_cnt); end
    tests++; if (nz_other != 0) begin fails++; $display("FAIL basic_idle_operands: got %0d nonzero cycles required 0", nz_other); end
    e = 0;
    for (int k = 0; k < N; k++)
      for (int j = 0; j < N; j++) begin
        if (capA[k][j*V +: V] != 8'(k + j)) e++;
        if (capB[k][j*V +: V] != ((k == j) ? 8'd1 : 8'd0)) e++;
      end
    tests++; if (e != 0) begin fails++; $display("FAIL basic_feed_values: got %0d wrong elements required 0", e); end
    stream_c();
    e = c_errors();
    tests++; if (e != 0) begin fails++; $display("FAIL basic_c: got %0d wrong entries required 0 (C[1][2]=%0d vs %0d)", e, oc[1][2], ec[1][2]); end
    step();
    tests++; if (busy !== 0 || done !== 0) begin fails++; $display("FAIL basic_after: busy=%b done=%b required 0 0", busy, done); end
  endtask

  task automatic test_extremes();
    int t, e;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ea[i][j] = -128;
        eb[i][j] = 127;
      end
    load(N);
    do_start(t);
    wait_done("extremes");
    stream_c();
    e = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (oc[i][j] != -162560) e++;
    tests++; if (e != 0) begin fails++; $display("FAIL extremes_c: got %0d wrong entries, C[0][0]=%0d required -162560", e, oc[0][0]); end
    tests++; if (capA[3][V-1:0] !== 8'h80) begin fails++; $display("FAIL extremes_a1: got %h required 80", capA[3][V-1:0]); end
    step();
  endtask

  task automatic test_back_to_back();
    int t1, t2, t3, e, c2;
    int exp1 [N][N];
    logic [W-1:0] junk;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ea[i][j] = i - j;
        eb[i][j] = (i == j) ? 2 : 0;
      end
    mult();
    exp1 = ec;
    load(N);
    do_start(t1);
    step();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ea[i][j] = j;
        eb[i][j] = 1;
      end
    mult();
    load(N);
    tests++; if (busy !== 1) begin fails++; $display("FAIL b2b_busy_at_start: got %b required 1", busy); end
    do_start(t2);
    tests++; if (ready !== 0) begin fails++; $display("FAIL b2b_ready_low: got %b required 0", ready); end
    // Shadow bank is locked now: this write and start must vanish.
    junk = {W{1'b0}};
    for (int j = 0; j < N; j++) junk[j*V +: V] = 8'h55;
    write_row(1'b0, 8'd0, junk);
    do_start(t3);
    tests++; if (ready !== 0) begin fails++; $display("FAIL lockout_ready: got %b required 0", ready); end
    wait_done("b2b_job1");
    stream_c();
    e = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (oc[i][j] != exp1[i][j]) e++;
    tests++; if (e != 0) begin fails++; $display("FAIL b2b_job1_c: got %0d wrong entries required 0", e); end
    tests++; if (ready !== 0) begin fails++; $display("FAIL b2b_ready_at_done: got %b required 0", ready); end
    step();
    tests++; if (ready !== 1) begin fails++; $display("FAIL b2b_ready_consumed: got %b required 1", ready); end
    wait_done("b2b_job2");
    tests++; if (gap != 1) begin fails++; $display("FAIL b2b_idle_gap: got %0d cycles required 1", gap); end
    stream_c();
    e = c_errors();
    tests++; if (e != 0) begin fails++; $display("FAIL b2b_job2_c: got %0d wrong entries, C[0][0]=%0d required %0d", e, oc[0][0], ec[0][0]); end
    c2 = clr_cyc;
    repeat (6) step();
    tests++; if (busy !== 0 || clr_cyc != c2) begin fails++; $display("FAIL lockout_start: busy=%b extra_clear=%0d required 0 0", busy, clr_cyc != c2); end
  endtask

  task automatic test_boundaries();
    int t, e;
    logic [W-1:0] fives;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ea[i][j] = (i == j) ? 1 : 0;
        eb[i][j] = i * 10 + j - 50;
      end
    load(N - 1);
    fives = '0;
    for (int j = 0; j < N; j++) fives[j*V +: V] = 8'd5;
    write_row(1'b0, 8'd10, fives);
    write_row(1'b0, 8'd128, fives);
    for (int j = 0; j < N; j++) eb[9][j] = 7;
    mult();
    wr_en   = 1'b1;
    wr_sel  = 1'b1;
    wr_idx  = 8'd9;
    wr_data = row_of(1'b1, 9);
    start   = 1'b1;
    t = cyc + 1;
    step();
    wr_en = 1'b0;
    start = 1'b0;
    wait_done("bounds");
    tests++; if (clr_cyc - t != 2) begin fails++; $display("FAIL bounds_clear_latency: got %0d required 2", clr_cyc - t); end
    stream_c();
    e = c_errors();
    tests++; if (e != 0) begin fails++; $display("FAIL bounds_c: got %0d wrong entries, C[9][0]=%0d C[0][0]=%0d required %0d %0d", e, oc[9][0], oc[0][0], ec[9][0], ec[0][0]); end
    step();
  endtask

  task automatic test_async_reset();
    int t, e;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ea[i][j] = (i * j) % 7 - 3;
        eb[i][j] = (i == j) ? 1 : 0;
      end
    load(N);
    do_start(t);
    // SHIFT output runs t+24..t+33; stop inside its fourth cycle.
    while (cyc < t + 27) step();
    tests++; if (shift !== 1) begin fails++; $display("FAIL arst_pre_shift: got %b required 1", shift); end
    #1;
    rst_n = 1'b0;
    #1;
    tests++; if (shift !== 0 || busy !== 0 || done !== 0) begin fails++; $display("FAIL arst_outputs: shift=%b busy=%b done=%b required 0 0 0", shift, busy, done); end
    tests++; if (ready !== 1) begin fails++; $display("FAIL arst_ready: got %b required 1", ready); end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step();
    // Only B rows 0..4 rewritten; rows 5..9 must read as zero after reset.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ea[i][j] = (i + 2 * j) % 9 - 4;
        eb[i][j] = (i == j && i < 5) ? 1 : 0;
      end
    mult();
    load(5);
    do_start(t);
    wait_done("arst_job");
    stream_c();
    e = c_errors();
    tests++; if (e != 0) begin fails++; $display("FAIL arst_c: got %0d wrong entries, C[0][7]=%0d required %0d", e, oc[0][7], ec[0][7]); end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_back_to_back();
    test_boundaries();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
